// File: rtl/delay_pkg.sv
// Shared helpers for the programmable delay line: select-field sizing,
// delay clamping and the per-edge update action of a channel.
package delay_pkg;

    typedef enum logic [1:0] {
        UPD_HOLD   = 2'd0,
        UPD_SHIFT  = 2'd1,
        UPD_CHANGE = 2'd2,
        UPD_CLEAR  = 2'd3
    } upd_e;

    function automatic int clog2(input int unsigned value);
        int          result;
        int unsigned span;
        result = 0;
        span   = 32'd1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // A select field must be able to hold 0..max_stages inclusive.
    function automatic int sel_width(input int unsigned max_stages);
        return clog2(max_stages + 32'd1);
    endfunction

    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_val);
        int unsigned result;
        if (sel > max_val) begin
            result = max_val;
        end else begin
            result = sel;
        end
        return result;
    endfunction

endpackage

// File: rtl/delay_chan.sv
// One channel of the programmable delay line: {valid,data} shift register,
// active delay register, change detection, output tap and occupancy counter.
module delay_chan
    import delay_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_STAGES = 16,
    parameter int SEL_W      = sel_width(MAX_STAGES)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_clear,
    input  logic [SEL_W-1:0]      i_delay_sel,
    input  logic                  i_din_valid,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_dout_valid,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic [SEL_W-1:0]      o_count
);

    logic [MAX_STAGES-1:0] r_valid;
    logic [DATA_WIDTH-1:0] r_data [MAX_STAGES];
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      r_count;

    logic [SEL_W-1:0]      w_sel_clamped;
    logic [SEL_W-1:0]      w_count_in;
    logic [SEL_W-1:0]      w_count_out;
    logic                  w_tap_valid;
    logic [DATA_WIDTH-1:0] w_tap_data;
    upd_e                  w_upd;

    assign w_sel_clamped = SEL_W'(clamp_sel(32'(i_delay_sel), 32'(MAX_STAGES)));
    assign w_count_in    = SEL_W'(i_din_valid);
    assign w_count_out   = SEL_W'(w_tap_valid);
    assign o_count       = r_count;

    // Per-edge action: CLEAR outranks a delay change, which outranks a plain shift.
    always_comb begin
        w_upd = UPD_HOLD;
        if (i_clear) begin
            w_upd = UPD_CLEAR;
        end else if (w_sel_clamped != r_sel) begin
            w_upd = UPD_CHANGE;
        end else if (i_en) begin
            w_upd = UPD_SHIFT;
        end else begin
            w_upd = UPD_HOLD;
        end
    end

    // Tap stage sel-1 as a one-hot OR so no out-of-range index is ever formed.
    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < MAX_STAGES; i++) begin
            w_tap_valid = w_tap_valid | (r_valid[i] & (r_sel == SEL_W'(i + 1)));
            w_tap_data  = w_tap_data | (r_data[i] & {DATA_WIDTH{r_sel == SEL_W'(i + 1)}});
        end
    end

    // Delay 0 is a combinational bypass; otherwise data is masked by its valid bit.
    always_comb begin
        if (r_sel == {SEL_W{1'b0}}) begin
            o_dout_valid = i_din_valid;
            o_dout       = i_din;
        end else begin
            o_dout_valid = w_tap_valid;
            o_dout       = w_tap_data & {DATA_WIDTH{w_tap_valid}};
        end
    end

    // Stage, delay and counter state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= {MAX_STAGES{1'b0}};
            for (int i = 0; i < MAX_STAGES; i++) begin
                r_data[i] <= {DATA_WIDTH{1'b0}};
            end
            r_sel   <= SEL_W'(MAX_STAGES);
            r_count <= {SEL_W{1'b0}};
        end else begin
            case (w_upd)
                UPD_CLEAR: begin
                    r_valid <= {MAX_STAGES{1'b0}};
                    for (int i = 0; i < MAX_STAGES; i++) begin
                        r_data[i] <= {DATA_WIDTH{1'b0}};
                    end
                    r_sel   <= w_sel_clamped;
                    r_count <= {SEL_W{1'b0}};
                end
                UPD_CHANGE: begin
                    // In-flight items are dropped; only this cycle's input survives.
                    r_valid   <= MAX_STAGES'(i_en & i_din_valid);
                    r_data[0] <= i_en ? i_din : {DATA_WIDTH{1'b0}};
                    r_sel     <= w_sel_clamped;
                    r_count   <= SEL_W'(i_en & i_din_valid & (w_sel_clamped != {SEL_W{1'b0}}));
                end
                UPD_SHIFT: begin
                    r_valid[0] <= i_din_valid;
                    r_data[0]  <= i_din;
                    for (int i = 1; i < MAX_STAGES; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_data[i]  <= r_data[i-1];
                    end
                    if (r_sel == {SEL_W{1'b0}}) begin
                        r_count <= {SEL_W{1'b0}};
                    end else begin
                        r_count <= r_count + w_count_in - w_count_out;
                    end
                end
                UPD_HOLD: begin
                    r_valid <= r_valid;
                    r_count <= r_count;
                end
                default: begin
                    r_valid <= r_valid;
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: rtl/delay_line_prog.sv
// Multi-channel runtime-programmable delay line; one delay_chan per channel
// sharing clock, reset, advance enable and flush.
module delay_line_prog
    import delay_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_STAGES = 16,
    parameter int SEL_W      = sel_width(MAX_STAGES)
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         EN,
    input  logic                         CLEAR,
    input  logic [NUM_CH*SEL_W-1:0]      DELAY_SEL,
    input  logic [NUM_CH-1:0]            DIN_VALID,
    input  logic [NUM_CH*DATA_WIDTH-1:0] DIN,
    output logic [NUM_CH-1:0]            DOUT_VALID,
    output logic [NUM_CH*DATA_WIDTH-1:0] DOUT,
    output logic [NUM_CH*SEL_W-1:0]      COUNT
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        delay_chan #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_STAGES (MAX_STAGES),
            .SEL_W      (SEL_W)
        ) u_chan (
            .i_clk        (CLK),
            .i_rst        (RESET),
            .i_en         (EN),
            .i_clear      (CLEAR),
            .i_delay_sel  (DELAY_SEL[c*SEL_W +: SEL_W]),
            .i_din_valid  (DIN_VALID[c]),
            .i_din        (DIN[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_dout_valid (DOUT_VALID[c]),
            .o_dout       (DOUT[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_count      (COUNT[c*SEL_W +: SEL_W])
        );
    end

endmodule

// File: tb/tb_delay_line_prog.sv
// Scoreboard bench for delay_line_prog: each accepted input is queued with the
// enabled-cycle stamp at which it must leave, and outputs are checked every cycle.
module tb_delay_line_prog;

    localparam int NUM_CH     = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_STAGES = 16;
    localparam int SEL_W      = 5;

    logic                         CLK = 1'b0;
    logic                         RESET;
    logic                         EN;
    logic                         CLEAR;
    logic [NUM_CH*SEL_W-1:0]      DELAY_SEL;
    logic [NUM_CH-1:0]            DIN_VALID;
    logic [NUM_CH*DATA_WIDTH-1:0] DIN;
    logic [NUM_CH-1:0]            DOUT_VALID;
    logic [NUM_CH*DATA_WIDTH-1:0] DOUT;
    logic [NUM_CH*SEL_W-1:0]      COUNT;

    typedef struct {
        int          ch;
        int unsigned due;
        logic [7:0]  data;
    } exp_item_t;

    exp_item_t   sb_q[$];
    int unsigned ecnt;
    int          sel_m [NUM_CH];
    int          n_chk;
    int          n_err;
    int          cyc;
    int          a5_in_cyc;
    int          a5_out_cyc;

    delay_line_prog #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_STAGES (MAX_STAGES)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .EN         (EN),
        .CLEAR      (CLEAR),
        .DELAY_SEL  (DELAY_SEL),
        .DIN_VALID  (DIN_VALID),
        .DIN        (DIN),
        .DOUT_VALID (DOUT_VALID),
        .DOUT       (DOUT),
        .COUNT      (COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_chk = n_chk + 1;
        if (obs_v !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs_v, exp_v, cyc);
        end
    endtask

    function automatic int clamp_m(input int v);
        return (v > MAX_STAGES) ? MAX_STAGES : v;
    endfunction

    task automatic set_sel(input int c, input int v);
        DELAY_SEL[c*SEL_W +: SEL_W] = 5'(v);
    endtask

    task automatic sb_flush(input int c);
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].ch == c) sb_q.delete(i);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        for (int c = 0; c < NUM_CH; c++) sel_m[c] = MAX_STAGES;
    endtask

    task automatic compare_outputs();
        logic       ev;
        logic [7:0] ed;
        int         ecn;
        for (int c = 0; c < NUM_CH; c++) begin
            ev  = 1'b0;
            ed  = 8'h00;
            ecn = 0;
            if (sel_m[c] == 0) begin
                ev = DIN_VALID[c];
                ed = DIN[c*8 +: 8];
            end else begin
                foreach (sb_q[i]) begin
                    if (sb_q[i].ch == c) begin
                        if (sb_q[i].due == ecnt) begin
                            ev = 1'b1;
                            ed = sb_q[i].data;
                        end
                        if (sb_q[i].due >= ecnt) ecn = ecn + 1;
                    end
                end
            end
            check_val($sformatf("dv%0d", c), 32'(DOUT_VALID[c]), 32'(ev));
            check_val($sformatf("dout%0d", c), 32'(DOUT[c*8 +: 8]), 32'(ed));
            check_val($sformatf("cnt%0d", c), 32'(COUNT[c*SEL_W +: SEL_W]), 32'(ecn));
        end
        if (a5_in_cyc >= 0 && a5_out_cyc < 0 && DOUT_VALID[0] && DOUT[7:0] == 8'hA5)
            a5_out_cyc = cyc;
    endtask

    task automatic model_update();
        int nv;
        if (!RESET) begin
            for (int c = 0; c < NUM_CH; c++) begin
                nv = clamp_m(int'(DELAY_SEL[c*SEL_W +: SEL_W]));
                if (CLEAR) begin
                    sb_flush(c);
                    sel_m[c] = nv;
                end else if (nv != sel_m[c]) begin
                    sb_flush(c);
                    sel_m[c] = nv;
                    if (EN && DIN_VALID[c] && nv != 0)
                        sb_q.push_back('{c, ecnt + 32'(nv), DIN[c*8 +: 8]});
                end else if (EN && DIN_VALID[c] && sel_m[c] != 0) begin
                    sb_q.push_back('{c, ecnt + 32'(sel_m[c]), DIN[c*8 +: 8]});
                end
            end
            if (EN) begin
                ecnt = ecnt + 32'd1;
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].due < ecnt) sb_q.delete(i);
                end
            end
        end
    endtask

    task automatic run_cycle();
        cyc = cyc + 1;
        @(negedge CLK);
        compare_outputs();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        cyc        = 0;
        ecnt       = 32'd0;
        a5_in_cyc  = -1;
        a5_out_cyc = -1;
        RESET      = 1'b1;
        EN         = 1'b0;
        CLEAR      = 1'b0;
        DELAY_SEL  = '0;
        DIN_VALID  = '0;
        DIN        = '0;
        model_reset();

        #12;
        check_val("rst_dv", 32'(DOUT_VALID), 32'd0);
        check_val("rst_dout", DOUT, 32'd0);
        check_val("rst_cnt", 32'(COUNT), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // fixed delay 3, counting data
        for (int c = 0; c < NUM_CH; c++) set_sel(c, 3);
        EN        = 1'b1;
        DIN_VALID = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            for (int c = 0; c < NUM_CH; c++) DIN[c*8 +: 8] = 8'(k + 32*c);
            run_cycle();
        end
        check_val("cnt_settle", 32'(COUNT[SEL_W-1:0]), 32'd3);

        // stall with 0xA5 in flight at delay 5
        for (int c = 0; c < NUM_CH; c++) set_sel(c, 5);
        DIN       = $urandom();
        DIN[7:0]  = 8'hA5;
        a5_in_cyc = cyc + 1;
        run_cycle();
        DIN_VALID = 4'h0;
        for (int k = 0; k < 2; k++) run_cycle();
        EN = 1'b0;
        for (int k = 0; k < 4; k++) run_cycle();
        EN = 1'b1;
        for (int k = 0; k < 8; k++) run_cycle();
        check_val("a5_lat", 32'(a5_out_cyc - a5_in_cyc), 32'd9);

        // bypass on ch0/ch2, clamp 31 -> 16 on ch1, 16 on ch3
        set_sel(0, 0);
        set_sel(1, 31);
        set_sel(2, 0);
        set_sel(3, 16);
        for (int k = 0; k < 24; k++) begin
            DIN_VALID = 4'($urandom());
            DIN       = $urandom();
            run_cycle();
        end
        DIN = $urandom();
        #1;
        check_val("byp_mid", 32'(DOUT[7:0]), 32'(DIN[7:0]));

        // delay change mid-stream on ch0 (4 -> 2); ch1 stays at 3
        for (int c = 0; c < NUM_CH; c++) set_sel(c, 4);
        set_sel(1, 3);
        DIN_VALID = 4'hF;
        for (int k = 0; k < 6; k++) begin
            DIN = $urandom();
            run_cycle();
        end
        set_sel(0, 2);
        DIN = $urandom();
        run_cycle();
        check_val("chg_cnt0", 32'(COUNT[SEL_W-1:0]), 32'd1);
        check_val("chg_cnt1", 32'(COUNT[2*SEL_W-1:SEL_W]), 32'd3);
        for (int k = 0; k < 5; k++) begin
            DIN = $urandom();
            run_cycle();
        end

        // CLEAR together with EN and a delay change
        CLEAR = 1'b1;
        for (int c = 0; c < NUM_CH; c++) set_sel(c, 6);
        DIN = $urandom();
        run_cycle();
        CLEAR = 1'b0;
        check_val("clr_dv", 32'(DOUT_VALID), 32'd0);
        check_val("clr_cnt", 32'(COUNT), 32'd0);
        for (int k = 0; k < 8; k++) begin
            DIN = $urandom();
            run_cycle();
        end

        // random traffic with stalls, flushes and delay changes
        for (int k = 0; k < 300; k++) begin
            EN    = ($urandom_range(0, 7) != 0);
            CLEAR = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 29) == 0) set_sel(c, $urandom_range(1, 31));
            end
            DIN_VALID = 4'($urandom());
            DIN       = $urandom();
            run_cycle();
        end
        CLEAR = 1'b0;
        EN    = 1'b1;

        // reset asserted between edges mid-stream
        for (int c = 0; c < NUM_CH; c++) set_sel(c, 3);
        DIN_VALID = 4'hF;
        for (int k = 0; k < 5; k++) begin
            DIN = $urandom();
            run_cycle();
        end
        RESET = 1'b1;
        #2;
        check_val("mrst_dv", 32'(DOUT_VALID), 32'd0);
        check_val("mrst_dout", DOUT, 32'd0);
        check_val("mrst_cnt", 32'(COUNT), 32'd0);
        model_reset();
        for (int c = 0; c < NUM_CH; c++) set_sel(c, 2);
        DIN_VALID = 4'h0;
        for (int k = 0; k < 2; k++) run_cycle();
        RESET     = 1'b0;
        DIN_VALID = 4'hF;
        for (int k = 0; k < 6; k++) begin
            DIN = $urandom();
            run_cycle();
        end
        DIN_VALID = 4'h0;
        for (int k = 0; k < 3; k++) run_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
